// File: rtl/frame_sel_pkg.sv
// rtl/frame_sel_pkg.sv - shared FSM states, routing field limits and helpers for frame_sel_sync
package frame_sel_pkg;

    localparam int SEL_FIELD_LSB = 4;
    localparam int SEL_FIELD_MSB = 7;
    localparam int NUM_CHANNELS  = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FRAME = 2'd1,
        ST_DROP  = 2'd2
    } state_e;

    function automatic logic sel_out_of_range(input logic [31:0] req);
        return req[SEL_FIELD_MSB:SEL_FIELD_LSB] >= 4'(NUM_CHANNELS);
    endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// rtl/axis_skid_buf.sv - 2-entry skid buffer (output register + skid register) with registered ready
module axis_skid_buf #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_in_data,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_out_data
);

    logic             r_out_valid;
    logic             r_skid_valid;
    logic             r_in_ready;
    logic [WIDTH-1:0] r_out_data;
    logic [WIDTH-1:0] r_skid_data;

    logic w_in_acc;
    logic w_out_free;
    logic w_skid_next;

    assign w_in_acc   = i_in_valid && r_in_ready;
    assign w_out_free = !r_out_valid || i_out_ready;
    // Skid only ever fills while the output register is stalled; it empties on the next free slot.
    assign w_skid_next = w_out_free ? 1'b0 : (r_skid_valid || w_in_acc);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b0;
            r_out_data   <= '0;
            r_skid_data  <= '0;
        end else begin
            if (w_out_free) begin
                if (r_skid_valid) begin
                    r_out_data  <= r_skid_data;
                    r_out_valid <= 1'b1;
                end else begin
                    r_out_valid <= w_in_acc;
                    if (w_in_acc) begin
                        r_out_data <= i_in_data;
                    end
                end
            end else if (w_in_acc) begin
                r_skid_data <= i_in_data;
            end
            r_skid_valid <= w_skid_next;
            r_in_ready   <= !w_skid_next;
        end
    end

    assign o_in_ready  = r_in_ready;
    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;

endmodule

// File: rtl/frame_sel_sync.sv
// rtl/frame_sel_sync.sv - SOF-synchronised channel select tagging; FRAME_SEL_SYNC_DROP_EN drops out-of-range frames
module frame_sel_sync #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  s_axis_aclk,
    input  logic                  s_axis_areset,
    input  logic [31:0]           channel_sel_req,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tuser,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,
    output logic [31:0]           channel_sel,
    output logic                  sof_err,
    output logic                  frame_drop
);
    import frame_sel_pkg::*;

    localparam int PW = DATA_WIDTH + 34;

    state_e       r_state;
    state_e       w_state_next;
    logic [31:0]  r_frame_sel;
    logic         r_sof_err;
    logic         w_hs;
    logic         w_bad_sel;
    logic         w_fwd;
    logic         w_sof_err_set;
    logic [31:0]  w_tag;
    logic [PW-1:0] w_in_data;
    logic [PW-1:0] w_out_data;

    assign w_hs = s_axis_tvalid && s_axis_tready;

`ifdef FRAME_SEL_SYNC_DROP_EN
    logic r_frame_drop;
    assign w_bad_sel = sel_out_of_range(channel_sel_req);

    always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
        if (s_axis_areset) r_frame_drop <= 1'b0;
        else               r_frame_drop <= w_hs && s_axis_tuser && w_bad_sel;
    end
    assign frame_drop = r_frame_drop;
`else
    assign w_bad_sel  = 1'b0;
    assign frame_drop = 1'b0;
`endif

    always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
        if (s_axis_areset) begin
            r_state     <= ST_IDLE;
            r_frame_sel <= '0;
            r_sof_err   <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_sof_err <= w_sof_err_set;
            if (w_hs && s_axis_tuser) begin
                r_frame_sel <= channel_sel_req;
            end
        end
    end

    // Any SOF restarts the frame regardless of state; tlast always closes it.
    always_comb begin
        w_state_next = r_state;
        if (w_hs) begin
            if (s_axis_tuser) begin
                if (s_axis_tlast)   w_state_next = ST_IDLE;
                else if (w_bad_sel) w_state_next = ST_DROP;
                else                w_state_next = ST_FRAME;
            end else if (s_axis_tlast) begin
                w_state_next = ST_IDLE;
            end
        end
    end

    always_comb begin
        w_fwd         = 1'b0;
        w_sof_err_set = 1'b0;
        w_tag         = r_frame_sel;
        if (w_hs) begin
            if (s_axis_tuser) begin
                w_sof_err_set = (r_state != ST_IDLE);
                w_fwd         = !w_bad_sel;
                w_tag         = channel_sel_req;
            end else begin
                w_fwd = (r_state == ST_FRAME);
            end
        end
    end

    assign w_in_data = {w_tag, s_axis_tuser, s_axis_tlast, s_axis_tdata};

    axis_skid_buf #(
        .WIDTH(PW)
    ) u_skid (
        .i_clk       (s_axis_aclk),
        .i_rst       (s_axis_areset),
        .i_in_valid  (w_fwd),
        .o_in_ready  (s_axis_tready),
        .i_in_data   (w_in_data),
        .o_out_valid (m_axis_tvalid),
        .i_out_ready (m_axis_tready),
        .o_out_data  (w_out_data)
    );

    assign {channel_sel, m_axis_tuser, m_axis_tlast, m_axis_tdata} = w_out_data;
    assign sof_err = r_sof_err;

endmodule

// File: tb/tb_frame_sel_sync.sv
// tb/tb_frame_sel_sync.sv - randomized self-checking bench for frame_sel_sync against a frame-rule model
module tb_frame_sel_sync;

`ifdef FRAME_SEL_SYNC_DROP_EN
    localparam bit DROP_BUILD = 1'b1;
`else
    localparam bit DROP_BUILD = 1'b0;
`endif

    typedef struct packed {
        logic [63:0] d;
        logic        l;
        logic        u;
        logic [31:0] s;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] req = '0;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic [63:0] s_tdata = '0;
    logic        s_tlast = 1'b0;
    logic        s_tuser = 1'b0;
    logic        m_tvalid;
    logic        m_tready = 1'b0;
    logic [63:0] m_tdata;
    logic        m_tlast;
    logic        m_tuser;
    logic [31:0] channel_sel;
    logic        sof_err;
    logic        frame_drop;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    beat_t exp_q[$];
    beat_t got_q[$];
    int    got_cyc[$];
    int    exp_sof, got_sof, exp_drop, got_drop;
    int    last_acc_cyc;
    bit    g_s_tready;
    bit    g_mr_rand = 1'b0;

    // model state: frame open / dropping, plus the latched frame tag
    bit          m_open = 1'b0;
    bit          m_dropping = 1'b0;
    logic [31:0] m_fsel = '0;

    frame_sel_sync #(.DATA_WIDTH(64)) dut (
        .s_axis_aclk     (clk),
        .s_axis_areset   (rst),
        .channel_sel_req (req),
        .s_axis_tvalid   (s_tvalid),
        .s_axis_tready   (s_tready),
        .s_axis_tdata    (s_tdata),
        .s_axis_tlast    (s_tlast),
        .s_axis_tuser    (s_tuser),
        .m_axis_tvalid   (m_tvalid),
        .m_axis_tready   (m_tready),
        .m_axis_tdata    (m_tdata),
        .m_axis_tlast    (m_tlast),
        .m_axis_tuser    (m_tuser),
        .channel_sel     (channel_sel),
        .sof_err         (sof_err),
        .frame_drop      (frame_drop)
    );

    always #5 clk = ~clk;

    function automatic void model_accept(input logic [63:0] d, input bit l, input bit u, input logic [31:0] r);
        if (u) begin
            if (m_open || m_dropping) exp_sof++;
            if (DROP_BUILD && r[7:4] > 4'd2) begin
                exp_drop++;
                m_dropping = !l;
                m_open     = 1'b0;
            end else begin
                exp_q.push_back('{d: d, l: l, u: 1'b1, s: r});
                m_fsel     = r;
                m_open     = !l;
                m_dropping = 1'b0;
            end
        end else if (m_open) begin
            exp_q.push_back('{d: d, l: l, u: 1'b0, s: m_fsel});
            if (l) m_open = 1'b0;
        end else if (m_dropping && l) begin
            m_dropping = 1'b0;
        end
    endfunction

    task automatic cycle(input bit v, input logic [63:0] d, input bit l, input bit u,
                         input logic [31:0] r, input bit mr, output bit acc);
        @(negedge clk);
        s_tvalid = v; s_tdata = d; s_tlast = l; s_tuser = u; req = r; m_tready = mr;
        #1;
        acc        = v && s_tready;
        g_s_tready = s_tready;
        if (m_tvalid && mr) begin
            got_q.push_back('{d: m_tdata, l: m_tlast, u: m_tuser, s: channel_sel});
            got_cyc.push_back(cyc);
        end
        if (sof_err) got_sof++;
        if (frame_drop) got_drop++;
        if (acc) begin
            model_accept(d, l, u, r);
            last_acc_cyc = cyc;
        end
        cyc++;
    endtask

    task automatic send(input logic [63:0] d, input bit l, input bit u, input logic [31:0] r);
        bit acc;
        for (int k = 0; k < 100; k++) begin
            cycle(1'b1, d, l, u, r, g_mr_rand ? 1'($urandom_range(0, 1)) : 1'b1, acc);
            if (acc) return;
        end
        total++; bad++;
        $display("FAIL send_timeout got=no_accept required=accept");
    endtask

    task automatic drain();
        bit acc;
        for (int k = 0; k < 8; k++) cycle(1'b0, '0, 1'b0, 1'b0, req, 1'b1, acc);
    endtask

    task automatic clear_sb();
        exp_q.delete(); got_q.delete(); got_cyc.delete();
        exp_sof = 0; got_sof = 0; exp_drop = 0; got_drop = 0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1; s_tvalid = 1'b0;
        repeat (2) @(negedge clk);
        clear_sb();
        m_open = 1'b0; m_dropping = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #2;
        total++;
        if ({m_tvalid, s_tready, channel_sel, m_tdata, m_tlast, m_tuser, sof_err, frame_drop} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got=%b/%b/%h/%h/%b/%b/%b/%b required=all_zero",
                     m_tvalid, s_tready, channel_sel, m_tdata, m_tlast, m_tuser, sof_err, frame_drop);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if (s_tready !== 1'b0) begin bad++; $display("FAIL reset_tready_low got=%b required=0", s_tready); end
        @(posedge clk); #1;
        total++;
        if (s_tready !== 1'b1) begin bad++; $display("FAIL reset_tready_rise got=%b required=1", s_tready); end
    endtask

    task automatic test_basic();
        int first_acc;
        clear_sb();
        g_mr_rand = 1'b0;
        send(64'hA0, 1'b0, 1'b1, 32'h10);
        first_acc = last_acc_cyc;
        send(64'hA1, 1'b0, 1'b0, 32'h10);
        send(64'hA2, 1'b0, 1'b0, 32'h10);
        send(64'hA3, 1'b1, 1'b0, 32'h10);
        drain();
        total++;
        if (got_q.size() !== 4) begin bad++; $display("FAIL basic_count got=%0d required=4", got_q.size()); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL basic_beat%0d got=%h required=%h", i, got_q[i], exp_q[i]); end
        end
        total++;
        if (got_cyc.size() == 0 || got_cyc[0] !== first_acc + 1) begin
            bad++; $display("FAIL basic_latency got=%0d required=%0d", got_cyc.size() ? got_cyc[0] - first_acc : -1, 1);
        end
        total++;
        if (m_tvalid !== 1'b0 || channel_sel !== 32'h10) begin
            bad++; $display("FAIL basic_sel_hold got=%b/%h required=0/00000010", m_tvalid, channel_sel);
        end
    endtask

    task automatic test_sel_change();
        clear_sb();
        send(64'hB0, 1'b0, 1'b1, 32'h00);
        send(64'hB1, 1'b0, 1'b0, 32'h20);
        send(64'hB2, 1'b0, 1'b0, 32'h20);
        send(64'hB3, 1'b1, 1'b0, 32'h20);
        send(64'hC0, 1'b0, 1'b1, 32'h20);
        send(64'hC1, 1'b1, 1'b0, 32'h00);
        drain();
        total++;
        if (got_q.size() !== exp_q.size()) begin bad++; $display("FAIL selchg_count got=%0d required=%0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL selchg_beat%0d got=%h required=%h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_backpressure();
        int  idx = 0;
        bit  saw_low = 1'b0;
        bit  acc;
        clear_sb();
        for (int t = 0; t < 40 && idx < 6; t++) begin
            cycle(1'b1, 64'hD0 + 64'(idx), idx == 5, idx == 0, 32'h10, !(t >= 2 && t < 5), acc);
            if (!g_s_tready) saw_low = 1'b1;
            if (acc) idx++;
        end
        drain();
        total++;
        if (!saw_low) begin bad++; $display("FAIL bp_tready_drop got=never_low required=low"); end
        total++;
        if (got_q.size() !== 6) begin bad++; $display("FAIL bp_count got=%0d required=6", got_q.size()); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL bp_beat%0d got=%h required=%h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_discard();
        apply_reset();
        for (int i = 0; i < 3; i++) send(64'hE0 + 64'(i), i == 2, 1'b0, 32'h10);
        send(64'hF0, 1'b0, 1'b1, 32'h00);
        send(64'hF1, 1'b1, 1'b0, 32'h00);
        drain();
        total++;
        if (got_q.size() !== 2) begin bad++; $display("FAIL discard_count got=%0d required=2", got_q.size()); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL discard_beat%0d got=%h required=%h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_sof_err();
        clear_sb();
        send(64'h100, 1'b0, 1'b1, 32'h10);
        send(64'h101, 1'b0, 1'b0, 32'h10);
        send(64'h102, 1'b0, 1'b1, 32'h20);
        send(64'h103, 1'b1, 1'b0, 32'h00);
        drain();
        total++;
        if (got_sof !== 1) begin bad++; $display("FAIL soferr_pulses got=%0d required=1", got_sof); end
        total++;
        if (got_q.size() !== 4) begin bad++; $display("FAIL soferr_count got=%0d required=4", got_q.size()); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL soferr_beat%0d got=%h required=%h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_drop();
        clear_sb();
        for (int i = 0; i < 5; i++) send(64'h200 + 64'(i), i == 4, i == 0, 32'h30);
        send(64'h300, 1'b0, 1'b1, 32'h10);
        send(64'h301, 1'b1, 1'b0, 32'h10);
        drain();
        total++;
        if (got_drop !== (DROP_BUILD ? 1 : 0)) begin bad++; $display("FAIL drop_pulses got=%0d required=%0d", got_drop, DROP_BUILD ? 1 : 0); end
        total++;
        if (got_q.size() !== (DROP_BUILD ? 2 : 7)) begin bad++; $display("FAIL drop_count got=%0d required=%0d", got_q.size(), DROP_BUILD ? 2 : 7); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL drop_beat%0d got=%h required=%h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid_frame();
        g_mr_rand = 1'b0;
        send(64'h400, 1'b0, 1'b1, 32'h20);
        send(64'h401, 1'b0, 1'b0, 32'h20);
        apply_reset();
        send(64'h402, 1'b0, 1'b0, 32'h20);
        send(64'h403, 1'b1, 1'b0, 32'h20);
        send(64'h500, 1'b1, 1'b1, 32'h10);
        drain();
        total++;
        if (got_q.size() !== 1) begin bad++; $display("FAIL rstmid_count got=%0d required=1", got_q.size()); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL rstmid_beat%0d got=%h required=%h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_random();
        logic [31:0] r;
        bit          acc;
        bit          v;
        bit          u;
        bit          l;
        logic [63:0] d;
        clear_sb();
        for (int n = 0; n < 400; n++) begin
            u = ($urandom_range(0, 5) == 0);
            l = ($urandom_range(0, 3) == 0);
            d = {$urandom, $urandom};
            r = $urandom;
            r[7:4] = 4'($urandom_range(0, 3));
            acc = 1'b0;
            for (int k = 0; k < 100 && !acc; k++) begin
                v = ($urandom_range(0, 9) < 7);
                cycle(v, d, l, u, r, 1'($urandom_range(0, 1)), acc);
            end
        end
        drain();
        total++;
        if (got_q.size() !== exp_q.size()) begin bad++; $display("FAIL rand_count got=%0d required=%0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL rand_beat%0d got=%h required=%h", i, got_q[i], exp_q[i]); end
        end
        total++;
        if (got_sof !== exp_sof) begin bad++; $display("FAIL rand_soferr got=%0d required=%0d", got_sof, exp_sof); end
        total++;
        if (got_drop !== exp_drop) begin bad++; $display("FAIL rand_drop got=%0d required=%0d", got_drop, exp_drop); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sel_change();
        test_backpressure();
        test_discard();
        test_sof_err();
        test_drop();
        test_reset_mid_frame();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
